// File: rtl/multiplex_display_n.sv
// -----------------------------------------------------------------------------
// multiplex_display_n
//
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Each digit owns a slot of REFRESH_CNT clocks. The first GHOST_CNT clocks of
// every slot keep all digits dark so the previous digit's charge can drain
// (anti-ghosting). The rest of the slot is PWM-gated by a brightness code
// that is sampled once per slot. Digit data and decimal points are captured
// into a snapshot once per frame, so a frame never shows a mix of old and
// new values.
//
// Optional build macro:
//   LZ_BLANK_EN  - when defined, leading zeros in the snapshot are blanked
//                  (digit 0 is never blanked; decimal points still honoured).
//
// Parameters:
//   NUM_DIGITS   number of digits (2..8)
//   REFRESH_CNT  clocks per digit slot (> GHOST_CNT + 1)
//   GHOST_CNT    dark clocks at the start of each slot (0..REFRESH_CNT-2)
//   BRIGHT_W     width of the brightness code
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active-high
//   digits_i         hex nibbles, digit k in bits [4k+3:4k], digit 0 rightmost
//   dp_i             per-digit decimal point request, active-high
//   display_en       0 blanks the display; counters keep running
//   brightness       PWM duty code
//   segments         active-low segments, [0]=a .. [6]=g
//   dp               active-low decimal point
//   enable_displays  active-low digit enables, at most one low
//   digit_idx        index of the current slot
//   frame_tick       one-cycle pulse in the first cycle of every frame
// -----------------------------------------------------------------------------
module multiplex_display_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_CNT = 1000,
  parameter int GHOST_CNT   = 8,
  parameter int BRIGHT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic                          display_en,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [6:0]                    segments,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         enable_displays,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_CNT);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Timing and data state.
  logic [CNT_W-1:0]                slot_q, slot_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [BRIGHT_W-1:0]             pwm_q, pwm_d;
  logic [BRIGHT_W-1:0]             bright_q, bright_d;
  logic [NUM_DIGITS-1:0][3:0]      snap_q, snap_d;
  logic [NUM_DIGITS-1:0]           dp_snap_q, dp_snap_d;
  logic                            slot_wrap;
  logic                            frame_wrap;

  // Next values of the output registers.
  logic                            lit_d;
  logic [6:0]                      seg_d;
  logic                            dp_d;
  logic [NUM_DIGITS-1:0]           en_d;

  // Slot/frame sequencing. The brightness code and the digit snapshot are
  // only sampled on wrap edges, so mid-slot or mid-frame input changes stay
  // invisible until the next boundary.
  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);

    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    pwm_d  = slot_wrap ? '0 : pwm_q + 1'b1;

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    bright_d = slot_wrap ? brightness : bright_q;

    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    if (frame_wrap) begin
      snap_d    = digits_i;
      dp_snap_d = dp_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      bright_q  <= '0;
      snap_q    <= '0;
      dp_snap_q <= '0;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      bright_q  <= bright_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
    end
  end

`ifdef LZ_BLANK_EN
  // Leading-zero mask over the snapshot that will be visible next cycle.
  // Scanning from the top digit down, a digit is blanked while no nonzero
  // digit has been seen at or above it. Digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  seen_nz;

  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (snap_d[k] != 4'h0) begin
        seen_nz = 1'b1;
      end
      lz_mask[k] = ~seen_nz;
    end
  end
`endif

  // Output decode works on the next-cycle view of the counters so that the
  // registered enables line up exactly with the slot they belong to: the
  // first cycle of a new slot is already dark, never a leftover of the old
  // digit. display_en is sampled here, which blanks within one cycle.
  always_comb begin
    lit_d = display_en && (slot_d >= GHOST_END) && (pwm_d <= bright_d);
    en_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit_d) begin
      en_d[idx_d] = 1'b0;
      seg_d       = hex_to_seg(snap_d[idx_d]);
`ifdef LZ_BLANK_EN
      if (lz_mask[idx_d]) begin
        seg_d = 7'h7F;
      end
`endif
      dp_d = ~dp_snap_d[idx_d];
    end
  end

  // Output registers; segments, dp and enables always move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segments        <= 7'h7F;
      dp              <= 1'b1;
      enable_displays <= '1;
      frame_tick      <= 1'b0;
    end else begin
      segments        <= seg_d;
      dp              <= dp_d;
      enable_displays <= en_d;
      frame_tick      <= frame_wrap;
    end
  end

  assign digit_idx = idx_q;

endmodule

// File: tb/tb_multiplex_display_n.sv
// -----------------------------------------------------------------------------
// tb_multiplex_display_n
//
// Drives multiplex_display_n (4 digits, 20-cycle slots, 2 ghost cycles,
// 2-bit brightness) through directed and randomized phases. Expected outputs
// come from a timeline model: everything is derived from the number of clock
// edges since reset release (slot = t mod 20, digit = t/20 mod 4), plus the
// values of the inputs captured at slot and frame boundaries.
// -----------------------------------------------------------------------------
module tb_multiplex_display_n;

  localparam int ND    = 4;
  localparam int RC    = 20;
  localparam int GC    = 2;
  localparam int BW    = 2;
  localparam int FRAME = ND * RC;

  logic            clk;
  logic            rst;
  logic [4*ND-1:0] digits_i;
  logic [ND-1:0]   dp_i;
  logic            display_en;
  logic [BW-1:0]   brightness;
  logic [6:0]      segments;
  logic            dp;
  logic [ND-1:0]   enable_displays;
  logic [1:0]      digit_idx;
  logic            frame_tick;

  multiplex_display_n #(
    .NUM_DIGITS (ND),
    .REFRESH_CNT(RC),
    .GHOST_CNT  (GC),
    .BRIGHT_W   (BW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .digits_i       (digits_i),
    .dp_i           (dp_i),
    .display_en     (display_en),
    .brightness     (brightness),
    .segments       (segments),
    .dp             (dp),
    .enable_displays(enable_displays),
    .digit_idx      (digit_idx),
    .frame_tick     (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Timeline model state.
  int          t;
  logic [3:0]  m_snap [ND];
  logic [ND-1:0] m_dp;
  logic [BW-1:0] m_bright;
  logic        m_en_prev;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    test_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, observed, expected);
    end
  endtask

  task automatic resetModel();
    t = 0;
    for (int k = 0; k < ND; k++) m_snap[k] = 4'h0;
    m_dp      = '0;
    m_bright  = '0;
    m_en_prev = 1'b0;
  endtask

  // Inputs seen at the edge that just happened become part of the model.
  task automatic modelEdge();
    t++;
    if (t % FRAME == 0) begin
      for (int k = 0; k < ND; k++) m_snap[k] = digits_i[4*k +: 4];
      m_dp = dp_i;
    end
    if (t % RC == 0) m_bright = brightness;
    m_en_prev = display_en;
  endtask

  task automatic checkOutput();
    int            slot;
    int            idx;
    logic          lit;
    logic          blank;
    logic [ND-1:0] exp_en;
    logic [6:0]    exp_seg;
    logic          exp_dp;
    logic          exp_tick;
    slot = t % RC;
    idx  = (t / RC) % ND;
    lit  = m_en_prev && (slot >= GC) && ((slot % (1 << BW)) <= int'(m_bright));
    blank = 1'b0;
`ifdef LZ_BLANK_EN
    if (idx != 0) begin
      blank = 1'b1;
      for (int j = idx; j < ND; j++) if (m_snap[j] != 4'h0) blank = 1'b0;
    end
`endif
    exp_en = '1;
    if (lit) exp_en[idx] = 1'b0;
    exp_seg  = (lit && !blank) ? seg_tab[m_snap[idx]] : 7'h7F;
    exp_dp   = lit ? ~m_dp[idx] : 1'b1;
    exp_tick = (t > 0) && (t % FRAME == 0);
    check("enable_displays", 32'(enable_displays), 32'(exp_en));
    check("segments", 32'(segments), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("digit_idx", 32'(digit_idx), 32'(idx));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
  endtask

  task automatic checkReset();
    check("rst_segments", 32'(segments), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_enables", 32'(enable_displays), 32'hF);
    check("rst_digit_idx", 32'(digit_idx), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
  endtask

  // mode 0: hold inputs; 1: new digits/dp every cycle;
  // 2: sparse random changes on every input; 3: zero-heavy digits.
  task automatic applyStimulus(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      modelEdge();
      checkOutput();
      case (mode)
        1: begin
          digits_i = 16'($urandom);
          dp_i     = 4'($urandom);
        end
        2: begin
          if ($urandom_range(0, 7) == 0)  digits_i   = 16'($urandom);
          if ($urandom_range(0, 15) == 0) dp_i       = 4'($urandom);
          if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
          display_en = ($urandom_range(0, 9) != 0);
        end
        3: begin
          if ($urandom_range(0, 9) == 0) begin
            for (int k = 0; k < ND; k++)
              digits_i[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            dp_i = 4'($urandom);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic runUntilSlot(input int target);
    int n;
    n = (target - (t % RC) + RC) % RC;
    if (n == 0) n = RC;
    applyStimulus(n, 0);
  endtask

  initial begin
    rst        = 1'b1;
    digits_i   = 16'($urandom);
    dp_i       = 4'($urandom);
    display_en = 1'b1;
    brightness = 2'd3;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkReset();

    // Release reset: first frame shows zeros, first slot uses brightness 0.
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput();
    applyStimulus(2 * FRAME, 0);

    // Known pattern, then a mid-frame change that must wait a frame.
    digits_i = 16'h12AF;
    dp_i     = 4'b0010;
    applyStimulus(FRAME + FRAME / 2, 0);
    digits_i = 16'h5C3E;
    dp_i     = 4'b1001;
    applyStimulus(2 * FRAME, 0);

    // Minimum brightness, then a mid-slot change to full.
    brightness = 2'd0;
    runUntilSlot(0);
    applyStimulus(RC + 10, 0);
    brightness = 2'd3;
    applyStimulus(2 * RC, 0);

    // display_en dropped and restored mid-slot.
    runUntilSlot(7);
    display_en = 1'b0;
    applyStimulus(5, 0);
    display_en = 1'b1;
    applyStimulus(2 * RC, 0);

    // Randomized phases.
    applyStimulus(3 * FRAME, 1);
    applyStimulus(10 * FRAME, 2);
    display_en = 1'b1;

    // Asynchronous reset mid-slot, checked before any clock edge.
    runUntilSlot(9);
    #2;
    rst = 1'b1;
    #1;
    checkReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput();
    applyStimulus(FRAME + RC, 0);

    // Leading-zero patterns and zero-heavy random data.
    digits_i   = 16'h0070;
    dp_i       = 4'b0100;
    brightness = 2'd3;
    applyStimulus(2 * FRAME, 0);
    digits_i = 16'h0000;
    dp_i     = 4'b0000;
    applyStimulus(2 * FRAME, 0);
    applyStimulus(6 * FRAME, 3);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
